uart_rx_ctrl: RTL

Parametrised UART receiver, the successor to the fixed 8N1 16x-oversampled receiver. Adds the following over that receiver:
- configurable bit period, data width, parity and stop bits
- majority-vote sampling
- false-start rejection
- per-character framing, parity and break error flags
- small output FIFO with valid/ready handshake and a sticky overrun flag

Sits between the board RX pin and the core's memory-mapped UART/peripheral logic.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_rx_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// FIFO entry layout and the sizes derived from the block parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;

  // Sample window centre (HALF) for a given bit period.
  function automatic int unsigned half_of(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  // Entry layout, LSB first: data[DATA_BITS-1:0], parity_err, frame_err, break.
  function automatic int unsigned perr_off(input int unsigned data_bits);
    return data_bits;
  endfunction

  function automatic int unsigned ferr_off(input int unsigned data_bits);
    return data_bits + 1;
  endfunction

  function automatic int unsigned brk_off(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

  // ENTRY_W for a given data width.
  function automatic int unsigned entry_w_of(input int unsigned data_bits);
    return data_bits + 3;
  endfunction

  // PTR_W for a given FIFO depth; the count is one bit wider.
  function automatic int unsigned ptr_w_of(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bus of the UART receiver: serial pin, FIFO head handshake
// with per-character flags, and status.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 uart_rx;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_parity_err;
  logic                 rd_frame_err;
  logic                 rd_break;
  logic                 overrun;
  logic                 overrun_clr;
  logic                 busy;

  modport master (
    input  uart_rx, rd_ready, overrun_clr,
    output rd_valid, rd_data, rd_parity_err, rd_frame_err, rd_break,
           overrun, busy
  );

  modport slave (
    output uart_rx, rd_ready, overrun_clr,
    input  rd_valid, rd_data, rd_parity_err, rd_frame_err, rd_break,
           overrun, busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received characters; a pop in the same cycle
// frees the slot for a push into a full FIFO.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = ptr_w_of(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Parametrised UART receiver: pin synchroniser, bit timer with 3-sample
// majority vote, character FSM and an output FIFO with sticky overrun.
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_ctrl_if.master  bus
);
  localparam int unsigned MID    = half_of(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS);
  localparam int unsigned ENT_W  = entry_w_of(DATA_BITS);
  localparam int unsigned FCNT_W = ptr_w_of(FIFO_DEPTH) + 1;
  localparam int unsigned PERR_B = perr_off(DATA_BITS);
  localparam int unsigned FERR_B = ferr_off(DATA_BITS);
  localparam int unsigned BRK_B  = brk_off(DATA_BITS);

  rx_state_e            state_q, state_d;
  logic                 s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 overrun_q, overrun_d;

  logic                 fall_c, maj_c, decide_c, wrap_c;
  logic                 ferr_now_c, brk_now_c, push_c, pop_c, drop_c;
  logic [ENT_W-1:0]     entry_c, head_c;
  logic                 fifo_full, fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;

  assign fall_c     = s3_q && !s2_q;
  assign maj_c      = (smp_q[0] & smp_q[1]) | (smp_q[0] & s2_q) | (smp_q[1] & s2_q);
  assign decide_c   = (state_q != ST_IDLE) && (bit_cnt_q == CNT_W'(MID + 1));
  assign wrap_c     = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign ferr_now_c = ferr_q || !maj_c;
  assign brk_now_c  = (data_q == '0) && ((PARITY_EN == 0) || !par_bit_q) && ferr_now_c;
  assign entry_c    = {brk_now_c, ferr_now_c, perr_q, data_q};
  assign pop_c      = !fifo_empty && bus.rd_ready;
  assign drop_c     = push_c && fifo_full && !pop_c;

  always_comb begin
    state_d    = state_q;
    s1_d       = bus.uart_rx;
    s2_d       = s1_q;
    s3_d       = s2_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    push_c     = 1'b0;
    overrun_d  = drop_c || (overrun_q && !bus.overrun_clr);

    // Bit timer and the two early votes of the sample window.
    if (state_q != ST_IDLE) begin
      bit_cnt_d = wrap_c ? '0 : bit_cnt_q + 1'b1;
      if (bit_cnt_q == CNT_W'(MID - 1)) smp_d[0] = s2_q;
      if (bit_cnt_q == CNT_W'(MID))     smp_d[1] = s2_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      ST_START: begin
        if (decide_c && maj_c) begin
          state_d = ST_IDLE;
        end else if (wrap_c) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (decide_c) data_d = {maj_c, data_q[DATA_BITS-1:1]};
        if (wrap_c) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (decide_c) begin
          perr_d    = (^{data_q, maj_c}) ^ (PARITY_ODD != 0);
          par_bit_d = maj_c;
        end
        if (wrap_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        // The last stop bit ends the character at its decision point.
        if (decide_c) begin
          ferr_d = ferr_now_c;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (wrap_c && state_d == ST_STOP) stop_idx_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      bit_cnt_q  <= '0;
      smp_q      <= 2'b11;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_bit_q  <= par_bit_d;
      overrun_q  <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (entry_c),
    .pop   (pop_c),
    .rdata (head_c),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.rd_valid      = !fifo_empty;
  assign bus.rd_data       = head_c[DATA_BITS-1:0];
  assign bus.rd_parity_err = head_c[PERR_B];
  assign bus.rd_frame_err  = head_c[FERR_B];
  assign bus.rd_break      = head_c[BRK_B];
  assign bus.overrun       = overrun_q;
  assign bus.busy          = (state_q != ST_IDLE);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= FCNT_W'(FIFO_DEPTH));
endmodule
